step_pulse_gen: RTL and testbench

Conditions the raw BTND push button into a clean, single-cycle step enable for the lab datapath. The 4-bit shift register and any later lab datapath advance one position per pulse. Pipeline: two-flop synchronizer, then a counter-based debouncer FSM, then a one-shot pulse with optional auto-repeat while the button is held. A wrapping pulse counter is exported for LED/7-seg debug.

---
 rtl/step_pulse_gen.sv | 107 ++++++++++
 tb/tb_step_pulse_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: synchronizes and debounces a push button into single-cycle step pulses,
// with optional auto-repeat while held and a wrapping pulse counter for debug displays.
module step_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       step,
    input  logic       autoRepeat,
    output logic       stepPulse,
    output logic       stepLevel,
    output logic [7:0] pulseCount
);
    localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CW = $clog2(MAX_ALL);
    localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] R_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] P_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [2:0] IDLE = 3'd0, PRESS_WAIT = 3'd1, HELD = 3'd2, REPEAT = 3'd3, RELEASE_WAIT = 3'd4;

    logic [1:0]    r_step_sync, r_rep_sync;
    logic [2:0]    r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          w_step, w_rep, w_pulse, w_level;

    assign w_step = r_step_sync[1];
    assign w_rep  = r_rep_sync[1];

    // Every waiting state counts consecutive qualifying samples and acts on the last one.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_pulse = 1'b0;
        w_level = stepLevel;
        case (r_state)
            IDLE: if (w_step) begin
                w_state = PRESS_WAIT;
                w_cnt   = ONE;
            end
            PRESS_WAIT: if (!w_step) begin
                w_state = IDLE;
                w_cnt   = '0;
            end else if (r_cnt == D_LAST) begin
                w_state = HELD;
                w_cnt   = '0;
                w_level = 1'b1;
                w_pulse = 1'b1;
            end else w_cnt = r_cnt + ONE;
            HELD: if (!w_step) begin
                w_state = RELEASE_WAIT;
                w_cnt   = ONE;
            end else if (!w_rep) w_cnt = '0;
            else if (r_cnt == R_LAST) begin
                w_state = REPEAT;
                w_cnt   = '0;
                w_pulse = 1'b1;
            end else w_cnt = r_cnt + ONE;
            REPEAT: if (!w_step) begin
                w_state = RELEASE_WAIT;
                w_cnt   = ONE;
            end else if (!w_rep) begin
                w_state = HELD;
                w_cnt   = '0;
            end else if (r_cnt == P_LAST) begin
                w_cnt   = '0;
                w_pulse = 1'b1;
            end else w_cnt = r_cnt + ONE;
            RELEASE_WAIT: if (w_step) begin
                w_state = HELD;
                w_cnt   = '0;
            end else if (r_cnt == D_LAST) begin
                w_state = IDLE;
                w_cnt   = '0;
                w_level = 1'b0;
            end else w_cnt = r_cnt + ONE;
            default: begin
                w_state = IDLE;
                w_cnt   = '0;
                w_level = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_step_sync <= '0;
            r_rep_sync  <= '0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            stepPulse   <= 1'b0;
            stepLevel   <= 1'b0;
            pulseCount  <= '0;
        end else begin
            r_step_sync <= {r_step_sync[0], step};
            r_rep_sync  <= {r_rep_sync[0], autoRepeat};
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            stepPulse   <= w_pulse;
            stepLevel   <= w_level;
            pulseCount  <= pulseCount + 8'(w_pulse);
        end
    end
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed and randomized checks of step_pulse_gen against a run-length
// reference model of the debounce and auto-repeat rules.
module tb_step_pulse_gen;
    localparam int D = 4, R = 10, P = 3;

    logic       clock = 1'b0, reset = 1'b1, step = 1'b0, autoRepeat = 1'b0;
    logic       stepPulse, stepLevel;
    logic [7:0] pulseCount;

    int tests = 0, fails = 0, e = 0, fall_e = -1;
    int pulse_q[$];
    logic lvl_prev = 1'b0;

    // Reference model: synchronizer taps, debounced level, run of samples opposing the level,
    // and a run of held-with-repeat samples since the last pulse.
    logic m_s1, m_s2, m_r1, m_r2, m_level, m_pulse, m_first;
    int   m_run, m_rep_run;
    logic [7:0] m_count;

    always #5 clock = ~clock;

    step_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(R), .REPEAT_PERIOD(P)) dut (
        .clock(clock), .reset(reset), .step(step), .autoRepeat(autoRepeat),
        .stepPulse(stepPulse), .stepLevel(stepLevel), .pulseCount(pulseCount)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            {m_s1, m_s2, m_r1, m_r2, m_level, m_pulse} = '0;
            m_first = 1'b1; m_run = 0; m_rep_run = 0; m_count = '0;
        end else begin
            m_pulse = 1'b0;
            if (!m_level) begin
                m_run = m_s2 ? m_run + 1 : 0;
                if (m_run == D) begin
                    m_level = 1'b1; m_pulse = 1'b1; m_run = 0; m_rep_run = 0; m_first = 1'b1;
                end
            end else if (!m_s2) begin
                m_run++; m_rep_run = 0; m_first = 1'b1;
                if (m_run == D) begin
                    m_level = 1'b0; m_run = 0;
                end
            end else if (m_run != 0) begin
                m_run = 0; m_rep_run = 0; m_first = 1'b1;
            end else if (m_r2) begin
                m_rep_run++;
                if (m_rep_run == (m_first ? R : P)) begin
                    m_pulse = 1'b1; m_rep_run = 0; m_first = 1'b0;
                end
            end else begin
                m_rep_run = 0; m_first = 1'b1;
            end
            m_count = m_count + 8'(m_pulse);
            m_s2 = m_s1; m_s1 = step;
            m_r2 = m_r1; m_r1 = autoRepeat;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("pulse", 8'(stepPulse), 8'(m_pulse));
        check("level", 8'(stepLevel), 8'(m_level));
        check("count", pulseCount, m_count);
        if (stepPulse) pulse_q.push_back(e);
        if (lvl_prev && !stepLevel) fall_e = e;
        lvl_prev = stepLevel;
        e++;
    endtask

    task automatic run(input logic s, input int n);
        step = s;
        repeat (n) tick();
    endtask

    function automatic logic [7:0] first_pulse();
        return (pulse_q.size() > 0) ? 8'(pulse_q[0]) : 8'hEE;
    endfunction

    int exp_rep[7] = '{5, 15, 18, 21, 24, 27, 30};

    initial begin
        repeat (2) tick();
        check("rst_pulse", 8'(stepPulse), 8'd0);
        check("rst_level", 8'(stepLevel), 8'd0);
        check("rst_count", pulseCount, 8'd0);
        reset = 1'b0;
        run(0, 3);
        // clean press
        pulse_q.delete(); e = 0;
        run(1, 8);
        check("press_n", 8'(pulse_q.size()), 8'd1);
        check("press_edge", first_pulse(), 8'(D + 1));
        check("press_level", 8'(stepLevel), 8'd1);
        check("press_count", pulseCount, 8'd1);
        run(0, 10);
        check("release_level", 8'(stepLevel), 8'd0);
        // press bounce
        pulse_q.delete(); e = 0;
        run(1, 2); run(0, 1); run(1, 10);
        check("bounce_n", 8'(pulse_q.size()), 8'd1);
        check("bounce_edge", first_pulse(), 8'(3 + D + 1));
        check("bounce_count", pulseCount, 8'd2);
        // release bounce
        pulse_q.delete(); e = 0; fall_e = -1;
        run(0, 2); run(1, 1); run(0, 8);
        check("relb_fall", 8'(fall_e), 8'(3 + D + 1));
        check("relb_n", 8'(pulse_q.size()), 8'd0);
        // auto-repeat
        autoRepeat = 1'b1;
        run(0, 3);
        pulse_q.delete(); e = 0;
        run(1, 31);
        autoRepeat = 1'b0;
        run(1, 10);
        check("rep_n", 8'(pulse_q.size()), 8'd7);
        for (int i = 0; i < 7; i++)
            check("rep_edge", (pulse_q.size() > i) ? 8'(pulse_q[i]) : 8'hEE, 8'(exp_rep[i]));
        check("rep_count", pulseCount, 8'd9);
        run(0, 10);
        // reset mid-hold
        run(1, 8);
        check("hold_level", 8'(stepLevel), 8'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_pulse", 8'(stepPulse), 8'd0);
        check("mid_rst_level", 8'(stepLevel), 8'd0);
        check("mid_rst_count", pulseCount, 8'd0);
        reset = 1'b0;
        pulse_q.delete(); e = 0;
        run(1, 8);
        check("rerun_edge", first_pulse(), 8'(D + 1));
        check("rerun_count", pulseCount, 8'd1);
        run(0, 10);
        // wrap
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 255; i++) begin
            run(1, 7); run(0, 8);
        end
        check("wrap_ff", pulseCount, 8'hFF);
        run(1, 7); run(0, 8);
        check("wrap_00", pulseCount, 8'h00);
        // randomized mix of bounces, holds, repeat toggles and resets
        for (int i = 0; i < 250; i++) begin
            autoRepeat = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 40) == 0);
            run(1'($urandom_range(0, 1)),
                $urandom_range(0, 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 25)));
        end
        reset = 1'b0;
        run(0, 12);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
